// File: rtl/acc_cfg_pkg.sv
// Shared constants and state encoding for the accelerator configuration sequencer.
package acc_cfg_pkg;

  localparam int NUM_HDR  = 9;
  localparam int NUM_REGS = 10;

  // Accelerator s0 register map: offset first, then the header words in order.
  localparam logic [3:0] REG_OFFSET  = 4'd0,
                         REG_IF_ROWS = 4'd1,
                         REG_IF_COLS = 4'd2,
                         REG_IF_CH   = 4'd3,
                         REG_W_ROWS  = 4'd4,
                         REG_W_COLS  = 4'd5,
                         REG_W_CH    = 4'd6,
                         REG_OF_ROWS = 4'd7,
                         REG_OF_COLS = 4'd8,
                         REG_STRIDE  = 4'd9;

  localparam int HDR_OF_ROWS = 6;
  localparam int HDR_OF_COLS = 7;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_HDR   = 3'd1,
    ST_WR_REG   = 3'd2,
    ST_START    = 3'd3,
    ST_WAIT_FIN = 3'd4,
    ST_ACK      = 3'd5
  } cfg_state_e;

endpackage

// File: rtl/acc_config_sequencer.sv
// Host-side job sequencer: fetches the layer header, programs the accelerator's
// s0 registers, runs Start/Finished/Finished_Ok and pulses Done at job end.
module acc_config_sequencer #(
  parameter logic [31:0] ADDR_OFFSET = 32'd9,
  parameter logic [31:0] HDR_BASE    = 32'd0,
  parameter int          NUM_HDR     = 9
) (
  input  logic        CFG_Clk,
  input  logic        CFG_Reset,
  input  logic        CFG_Go,
  output logic [31:0] CFG_mem_address,
  output logic        CFG_mem_read,
  input  logic [31:0] CFG_mem_readdata,
  input  logic        CFG_mem_waitrequest,
  output logic [3:0]  CFG_s0_address,
  output logic        CFG_s0_write,
  output logic        CFG_s0_chipselect,
  output logic [31:0] CFG_s0_writedata,
  output logic        CFG_Start,
  input  logic        CFG_Finished,
  output logic        CFG_Finished_Ok,
  output logic [31:0] CFG_Final_Addr,
  output logic        CFG_Busy,
  output logic        CFG_Done,
  output logic [2:0]  CFG_Dbg_State
);
  import acc_cfg_pkg::*;

  localparam logic [3:0] K_LAST = 4'(NUM_HDR - 1);

  cfg_state_e  state_q;
  logic [3:0]  k_q;
  logic [31:0] hdr_q [NUM_HDR];
  logic [31:0] mem_address_q;
  logic        mem_read_q;
  logic [3:0]  s0_address_q;
  logic        s0_write_q;
  logic [31:0] s0_writedata_q;
  logic        start_q;
  logic        fin_ok_q;
  logic [31:0] final_addr_q;
  logic        busy_q;
  logic        done_q;

  // Read handshake: a beat completes on any edge where read is high and
  // waitrequest is low; read and address stay put while waitrequest is high.
  always_ff @(posedge CFG_Clk or negedge CFG_Reset) begin
    if (!CFG_Reset) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      mem_address_q  <= '0;
      mem_read_q     <= 1'b0;
      s0_address_q   <= '0;
      s0_write_q     <= 1'b0;
      s0_writedata_q <= '0;
      start_q        <= 1'b0;
      fin_ok_q       <= 1'b0;
      final_addr_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      for (int i = 0; i < NUM_HDR; i++) hdr_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (CFG_Go) begin
            state_q       <= ST_RD_HDR;
            k_q           <= '0;
            mem_read_q    <= 1'b1;
            mem_address_q <= HDR_BASE;
            busy_q        <= 1'b1;
          end
        end

        ST_RD_HDR: begin
          if (!CFG_mem_waitrequest) begin
            hdr_q[k_q] <= CFG_mem_readdata;
            if (k_q == K_LAST) begin
              state_q        <= ST_WR_REG;
              mem_read_q     <= 1'b0;
              mem_address_q  <= '0;
              s0_write_q     <= 1'b1;
              s0_address_q   <= REG_OFFSET;
              s0_writedata_q <= ADDR_OFFSET;
              // of_rows/of_cols were captured on earlier beats; wraps modulo 2^32.
              final_addr_q   <= hdr_q[HDR_OF_ROWS] * hdr_q[HDR_OF_COLS] - 32'd1 + ADDR_OFFSET;
            end else begin
              k_q           <= k_q + 4'd1;
              mem_address_q <= HDR_BASE + 32'(k_q) + 32'd1;
            end
          end
        end

        ST_WR_REG: begin
          if (s0_address_q == REG_STRIDE) begin
            state_q        <= ST_START;
            s0_write_q     <= 1'b0;
            s0_address_q   <= '0;
            s0_writedata_q <= '0;
            start_q        <= 1'b1;
          end else begin
            // Register a+1 carries header word a.
            s0_address_q   <= s0_address_q + 4'd1;
            s0_writedata_q <= hdr_q[s0_address_q];
          end
        end

        ST_START: begin
          start_q <= 1'b0;
          state_q <= ST_WAIT_FIN;
        end

        ST_WAIT_FIN: begin
          if (CFG_Finished) begin
            fin_ok_q <= 1'b1;
            state_q  <= ST_ACK;
          end
        end

        ST_ACK: begin
          // Done is raised while still in ACK, so a Go in that cycle is ignored.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (!CFG_Finished) begin
            fin_ok_q <= 1'b0;
            done_q   <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CFG_mem_address   = mem_address_q;
  assign CFG_mem_read      = mem_read_q;
  assign CFG_s0_address    = s0_address_q;
  assign CFG_s0_write      = s0_write_q;
  assign CFG_s0_chipselect = s0_write_q;
  assign CFG_s0_writedata  = s0_writedata_q;
  assign CFG_Start         = start_q;
  assign CFG_Finished_Ok   = fin_ok_q;
  assign CFG_Final_Addr    = final_addr_q;
  assign CFG_Busy          = busy_q;
  assign CFG_Done          = done_q;
  assign CFG_Dbg_State     = state_q;

endmodule

// File: tb/tb_acc_config_sequencer.sv
// Bench for acc_config_sequencer: plays memory and accelerator, and checks every
// cycle against a job timeline derived from header contents and stall plan.
module tb_acc_config_sequencer;

  localparam logic [31:0] OFFS = 32'd9;
  localparam logic [31:0] BASE = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata;
  logic        waitreq = 1'b0;
  logic [3:0]  s0_address;
  logic        s0_write;
  logic        s0_cs;
  logic [31:0] s0_writedata;
  logic        start;
  logic        finished = 1'b0;
  logic        fin_ok;
  logic [31:0] final_addr;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  acc_config_sequencer #(.ADDR_OFFSET(OFFS), .HDR_BASE(BASE), .NUM_HDR(9)) dut (
    .CFG_Clk            (clk),
    .CFG_Reset          (rst_n),
    .CFG_Go             (go),
    .CFG_mem_address    (mem_address),
    .CFG_mem_read       (mem_read),
    .CFG_mem_readdata   (mem_readdata),
    .CFG_mem_waitrequest(waitreq),
    .CFG_s0_address     (s0_address),
    .CFG_s0_write       (s0_write),
    .CFG_s0_chipselect  (s0_cs),
    .CFG_s0_writedata   (s0_writedata),
    .CFG_Start          (start),
    .CFG_Finished       (finished),
    .CFG_Finished_Ok    (fin_ok),
    .CFG_Final_Addr     (final_addr),
    .CFG_Busy           (busy),
    .CFG_Done           (done),
    .CFG_Dbg_State      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- memory model ----------------
  logic [31:0] mem [16];
  assign mem_readdata = mem[mem_address[3:0]];

  // ---------------- job model ----------------
  logic [31:0] hdr_m [9];
  int          stalls [9];
  bit          job_on = 1'b0;
  int          go_cyc, t0, tw, ts, fin_at, fin_len, td;
  int          rd_idx, st_used, obs_start, ok_cnt, rd4_cnt;
  logic [31:0] final_exp = '0;
  logic [31:0] final_prev = '0;
  logic [35:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  logic        e_rd, e_wr, e_busy;
  logic [35:0] exp_w;

  always @(negedge clk) begin
    e_rd   = job_on && cyc >= t0 && cyc < tw;
    e_wr   = job_on && cyc >= tw && cyc < ts;
    e_busy = job_on && cyc >= t0 && cyc <= td;
    check("busy", busy, e_busy);
    if (!e_busy) check("dbg_idle", dbg_state, 3'(acc_cfg_pkg::ST_IDLE));
    check("mem_read", mem_read, e_rd);
    if (e_rd && mem_read) check("mem_address", mem_address, BASE + 32'(rd_idx));
    check("s0_write", s0_write, e_wr);
    check("s0_cs", s0_cs, e_wr);
    if (e_wr && exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      check("s0_address", s0_address, exp_w[35:32]);
      check("s0_writedata", s0_writedata, exp_w[31:0]);
    end
    check("start", start, job_on && cyc == ts);
    check("fin_ok", fin_ok, job_on && cyc >= fin_at + 1 && cyc <= fin_at + fin_len);
    check("done", done, job_on && cyc == td);
    check("final_addr", final_addr, (job_on && cyc >= tw) ? final_exp : final_prev);

    if (start) obs_start = cyc;
    if (fin_ok) ok_cnt++;
    if (mem_read && mem_address == BASE + 32'd4) rd4_cnt++;

    // Drive memory stalls for this cycle and the accelerator's Finished.
    if (job_on && mem_read && rd_idx < 9 && st_used < stalls[rd_idx]) begin
      waitreq = 1'b1;
      st_used++;
    end else begin
      waitreq = mem_read ? 1'b0 : 1'($urandom_range(0, 1));
      if (job_on && mem_read) begin
        rd_idx++;
        st_used = 0;
      end
    end
    finished = job_on && cyc >= fin_at && cyc < fin_at + fin_len;
  end

  // ---------------- driver tasks ----------------
  task automatic launch(input int d, input int l);
    int s;
    s = 0;
    for (int i = 0; i < 9; i++) begin
      mem[i] = hdr_m[i];
      s += stalls[i];
    end
    @(negedge clk); #2;
    final_prev = final_exp;
    final_exp  = hdr_m[6] * hdr_m[7] - 32'd1 + OFFS;
    go_cyc  = cyc;
    t0      = cyc + 1;
    tw      = t0 + 9 + s;
    ts      = tw + 10;
    fin_at  = ts + d;
    fin_len = l;
    td      = fin_at + l + 1;
    rd_idx = 0; st_used = 0; ok_cnt = 0; rd4_cnt = 0; obs_start = -1;
    exp_q.delete();
    exp_q.push_back({4'd0, OFFS});
    for (int i = 0; i < 9; i++) exp_q.push_back({4'(i + 1), hdr_m[i]});
    job_on = 1'b1;
    go = 1'b1;
    @(negedge clk); #2;
    go = 1'b0;
  endtask

  task automatic finish_job(input bit go_noise);
    while (cyc <= td + 1) begin
      @(negedge clk); #2;
      go = go_noise && (cyc == ts + 3 || cyc == td);
    end
    go = 1'b0;
    check("wr_queue_drained", exp_q.size(), 0);
  endtask

  task automatic rand_header();
    for (int i = 0; i < 9; i++) hdr_m[i] = $urandom;
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 9; i++) stalls[i] = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 9; i++) hdr_m[i] = '0;
    clear_stalls();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Reference layer header, no stalls.
    hdr_m = '{32'd28, 32'd28, 32'd1, 32'd3, 32'd3, 32'd1, 32'd26, 32'd26, 32'd1};
    launch(50, 5);
    check("model_final_684", final_exp, 32'd684);
    finish_job(1'b0);
    check("go_to_start", 32'(obs_start + 1 - go_cyc), 32'd21);
    check("final_684", final_addr, 32'd684);
    check("fin_ok_cycles", 32'(ok_cnt), 32'd5);

    // Three stall cycles on beat 4.
    stalls[4] = 3;
    launch(3, 2);
    finish_job(1'b0);
    check("go_to_start_stall", 32'(obs_start + 1 - go_cyc), 32'd24);
    check("addr4_hold", 32'(rd4_cnt), 32'd4);
    clear_stalls();

    // Reset during the fifth register write, then a fresh job.
    rand_header();
    launch(20, 2);
    while (cyc != tw + 4) begin
      @(negedge clk); #2;
    end
    rst_n = 1'b0;
    job_on = 1'b0;
    exp_q.delete();
    final_exp = '0;
    final_prev = '0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_s0_write", s0_write, 1'b0);
    check("rst_s0_address", s0_address, 4'd0);
    check("rst_s0_writedata", s0_writedata, 32'd0);
    check("rst_final", final_addr, 32'd0);
    check("rst_start", start, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    launch(4, 2);
    finish_job(1'b0);

    // Zero output size plus Go noise in WAIT_FIN and the Done cycle.
    rand_header();
    hdr_m[6] = 32'd0;
    hdr_m[7] = 32'd0;
    launch(10, 3);
    finish_job(1'b1);
    check("final_zero", final_addr, 32'd8);

    // Product wraps to zero.
    rand_header();
    hdr_m[6] = 32'd65536;
    hdr_m[7] = 32'd65536;
    launch(1, 1);
    finish_job(1'b0);
    check("final_wrap", final_addr, 32'd8);

    // Randomized jobs.
    repeat (8) begin
      rand_header();
      for (int i = 0; i < 9; i++)
        stalls[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      d = int'($urandom_range(1, 12));
      launch(d, int'($urandom_range(1, 4)));
      finish_job(d >= 4 && $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_config_sequencer.md
# acc_config_sequencer

- Synthesizable host-side sequencer that replaces the software/bench host in front of the accelerator's Avalon slave.
- Per job it:
  - reads the 9-word layer header from off-chip memory through an Avalon-MM read master;
  - programs the accelerator's 10 configuration registers through the accelerator's s0 slave;
  - pulses Start and waits for Finished;
  - returns Finished_Ok and reports completion.
- It is the initiator counterpart of the accelerator's s0 register slave and conduit handshake.

## Interface
Parameters:
- ADDR_OFFSET, 9, data offset written to accelerator register 0.
- HDR_BASE, 0, word address of header word 0 in off-chip memory.
- NUM_HDR, 9, header words: if_rows, if_cols, if_ch, w_rows, w_cols, w_ch, of_rows, of_cols, stride.

Ports:
- CFG_Clk  in  1  single clock.
- CFG_Reset  in  1  asynchronous, active-low reset.
- CFG_Go  in  1  start-job request, sampled in IDLE only.
- CFG_mem_address  out  32  header read word address.
- CFG_mem_read  out  1  read request.
- CFG_mem_readdata  in  32  read data.
- CFG_mem_waitrequest  in  1  memory stall.
- CFG_s0_address  out  4  accelerator register index.
- CFG_s0_write  out  1  register write strobe.
- CFG_s0_chipselect  out  1  high with every write.
- CFG_s0_writedata  out  32  register value.
- CFG_Start  out  1  to accelerator Start conduit.
- CFG_Finished  in  1  from accelerator Finished conduit.
- CFG_Finished_Ok  out  1  to accelerator Finished_Ok conduit.
- CFG_Final_Addr  out  32  of_rows*of_cols-1+ADDR_OFFSET, last output word address.
- CFG_Busy  out  1  high outside IDLE.
- CFG_Done  out  1  one-cycle pulse at job end.

## Operation
- FSM states: IDLE → RD_HDR → WR_REG → START → WAIT_FIN → ACK → IDLE.
- IDLE
  - On CFG_Go=1: clear read index k and enter RD_HDR.
  - CFG_Go is ignored in every other state.
- RD_HDR
  - CFG_mem_read=1, CFG_mem_address=HDR_BASE+k.
  - Zero-latency Avalon read: a beat completes in the cycle read=1 and waitrequest=0.
  - On completion, readdata is captured into hdr[k] and k increments.
  - Read stays asserted, with address held, while waitrequest=1.
  - After beat k=NUM_HDR-1, enter WR_REG.
- WR_REG
  - 10 back-to-back single-cycle writes; write=chipselect=1 every cycle.
  - Address 0 carries ADDR_OFFSET; addresses 1..9 carry hdr[0..8].
  - The s0 slave has no waitrequest, so one write per cycle is unconditional.
- START: CFG_Start=1 for exactly one cycle.
- WAIT_FIN: wait for CFG_Finished=1. There is no timeout.
- ACK
  - CFG_Finished_Ok=1, held until CFG_Finished returns to 0.
  - In that exit cycle: CFG_Done=1, then IDLE.
- Arithmetic
  - CFG_Final_Addr = hdr[6]*hdr[7]-1+ADDR_OFFSET, computed modulo 2^32.
  - Registered once on entry to WR_REG; held until the next job's entry to WR_REG.
  - of_rows*of_cols=0 yields ADDR_OFFSET-1. No saturation.

## Timing
- Reset values, all outputs: mem_address=0, mem_read=0, s0_address=0, s0_write=0, s0_chipselect=0, s0_writedata=0, Start=0, Finished_Ok=0, Final_Addr=0, Busy=0, Done=0. hdr[] cleared, state IDLE.
- Reset mid-operation: immediate return to the reset state. An in-flight read is abandoned; no partial write completes after reset.
- All outputs are registered. CFG_Go sampled at edge n gives CFG_mem_read=1 in cycle n+1.
- With no waitrequest, RD_HDR lasts 9 cycles, WR_REG 10 cycles, START 1 cycle. Go-to-Start latency is 21 cycles.
- Each waitrequest cycle adds exactly one cycle.
- CFG_Finished already 1 on entry to WAIT_FIN: move to ACK on the next cycle.
- CFG_Go=1 in the same cycle Done pulses: ignored, because the FSM is still in ACK. A new job needs Go while in IDLE.

## Structure
- Package acc_cfg_pkg holds:
  - the state enum;
  - NUM_HDR and NUM_REGS=10;
  - named register indices REG_OFFSET=0 … REG_STRIDE=9;
  - header word indices HDR_OF_ROWS=6 and HDR_OF_COLS=7.
- A single module is natural; the header buffer is a 9×32 register array inside it.
- The read-master beat logic may be split into submodule avmm_read_beat if reused, but it is not required.

## Test plan
- Header {28,28,1,3,3,1,26,26,1}, no waitrequest:
  - 9 reads at addresses 0..8;
  - writes (0,9),(1,28),(2,28),(3,1),(4,3),(5,3),(6,1),(7,26),(8,26),(9,1) on consecutive cycles;
  - Start 21 cycles after Go;
  - Final_Addr=684.
- waitrequest=1 for 3 cycles on beat k=4: address 4 held for 4 cycles, hdr[4] correct, Start at Go+24.
- Finished asserted 50 cycles after Start and held 5 cycles: Finished_Ok high for those 5 cycles, Done one cycle as Finished falls, Busy=0 the cycle after.
- CFG_Reset low during the 5th WR_REG write: all outputs 0 immediately, no further s0 writes; a fresh Go restarts the job from read address 0.
- Go pulsed during WAIT_FIN and in the Done cycle: no effect. Header {…,0,0,…} (of_rows=of_cols=0): Final_Addr=8.
- Header {…,65536,65536,…}: product wraps to 0, so Final_Addr=8.
